// File: rtl/sha256_dma_fetch.sv
// sha256_dma_fetch
// Read-side DMA sequencer for the SHA256 engine. A start command fetches
// 1..16 consecutive 64-bit words from system memory with single-beat reads
// and streams each word, tagged with its index, to the message-schedule
// loader. Alignment, length and per-phase timeout are checked. Errors are
// sticky until abort_i or reset.
//
// Ports
//   axi_clk_i, axi_rstn_i     clock, asynchronous active-low reset
//   start_i, abort_i          command pulses
//   base_addr_i, nwords_i     transfer parameters, sampled at start
//   busy_o, done_o            status (busy in REQ/REL, done is a pulse)
//   err_o, err_code_o         sticky error (1 bus, 2 timeout, 3 bad params)
//   word_o, word_idx_o,
//   word_valid_o              captured word stream towards the loader
//   axi_raddr_o, axi_rvalid_o,
//   axi_rsel_o, axi_rlen_o,
//   axi_rfixed_o              read request side of the client bus
//   axi_rdata_i, axi_rrdy_i,
//   axi_rerr_i                read response side of the client bus
//
// Handshake (four-phase, single beat): the master raises axi_rvalid_o with
// a stable address; the slave answers by raising axi_rrdy_i with data (or
// axi_rerr_i); the master drops axi_rvalid_o; the slave drops axi_rrdy_i;
// only then may the next request be raised.
`timescale 1ns/1ps
module sha256_dma_fetch #(
   parameter int TIMEOUT = 255
) (
   input  logic        axi_clk_i,
   input  logic        axi_rstn_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [31:0] base_addr_i,
   input  logic [4:0]  nwords_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [1:0]  err_code_o,
   output logic [63:0] word_o,
   output logic [3:0]  word_idx_o,
   output logic        word_valid_o,
   output logic [31:0] axi_raddr_o,
   output logic        axi_rvalid_o,
   output logic [7:0]  axi_rsel_o,
   output logic [3:0]  axi_rlen_o,
   output logic        axi_rfixed_o,
   input  logic [63:0] axi_rdata_i,
   input  logic        axi_rrdy_i,
   input  logic        axi_rerr_i
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_ERR} state_t;

   state_t        state_q, state_d;
   logic [3:0]    idx_q, idx_d;
   logic [4:0]    nwords_q, nwords_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    code_q, code_d;
   logic          done_q, done_d;
   logic          wvalid_q, wvalid_d;
   logic [63:0]   word_q, word_d;
   logic [3:0]    widx_q, widx_d;
   logic [31:0]   raddr_q, raddr_d;
   logic          last_word;
   logic          tmo_hit;

   assign last_word = (({1'b0, idx_q} + 5'd1) == nwords_q);
   // The counter starts at 0 on state entry, so the phase has lasted
   // TIMEOUT cycles when it shows TIMEOUT-1 at the deciding edge.
   assign tmo_hit   = (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
      if (!axi_rstn_i) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         nwords_q <= '0;
         cnt_q    <= '0;
         code_q   <= '0;
         done_q   <= 1'b0;
         wvalid_q <= 1'b0;
         word_q   <= '0;
         widx_q   <= '0;
         raddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         nwords_q <= nwords_d;
         cnt_q    <= cnt_d;
         code_q   <= code_d;
         done_q   <= done_d;
         wvalid_q <= wvalid_d;
         word_q   <= word_d;
         widx_q   <= widx_d;
         raddr_q  <= raddr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      nwords_d = nwords_q;
      cnt_d    = cnt_q;
      code_d   = code_q;
      done_d   = 1'b0;
      wvalid_d = 1'b0;
      word_d   = word_q;
      widx_d   = widx_q;
      raddr_d  = raddr_q;
      if (abort_i) begin
         state_d = S_IDLE;
         code_d  = 2'd0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if ((base_addr_i[2:0] != 3'd0) || (nwords_i > 5'd16)) begin
                     state_d = S_ERR;
                     code_d  = 2'd3;
                  end else if (nwords_i == 5'd0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d  = S_REQ;
                     raddr_d  = base_addr_i;
                     nwords_d = nwords_i;
                     idx_d    = '0;
                     cnt_d    = '0;
                  end
               end
            end
            S_REQ: begin
               // A bus error wins over a simultaneous ready.
               if (axi_rerr_i) begin
                  state_d = S_ERR;
                  code_d  = 2'd1;
               end else if (axi_rrdy_i) begin
                  state_d  = S_REL;
                  word_d   = axi_rdata_i;
                  widx_d   = idx_q;
                  wvalid_d = 1'b1;
                  cnt_d    = '0;
               end else if (tmo_hit) begin
                  state_d = S_ERR;
                  code_d  = 2'd2;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_REL: begin
               if (!axi_rrdy_i) begin
                  cnt_d = '0;
                  if (last_word) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_REQ;
                     idx_d   = idx_q + 4'd1;
                     // Address wraps modulo 2^32 without an error.
                     raddr_d = raddr_q + 32'd8;
                  end
               end else if (tmo_hit) begin
                  state_d = S_ERR;
                  code_d  = 2'd2;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_ERR: begin
               state_d = S_ERR;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Status flags decode straight from the state register, so they drop
   // together with the asynchronous reset.
   assign busy_o       = (state_q == S_REQ) || (state_q == S_REL);
   assign axi_rvalid_o = (state_q == S_REQ);
   assign err_o        = (state_q == S_ERR);
   assign err_code_o   = code_q;
   assign done_o       = done_q;
   assign word_o       = word_q;
   assign word_idx_o   = widx_q;
   assign word_valid_o = wvalid_q;
   assign axi_raddr_o  = raddr_q;
   assign axi_rsel_o   = 8'hFF;
   assign axi_rlen_o   = 4'h1;
   assign axi_rfixed_o = 1'b0;

endmodule
